// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave that deserialises MSB-first command frames and serialises read data back
// Ports: clk/rst_n system clock and async active-low reset; ss_n/mosi/miso SPI pins;
//        rx_data/rx_valid completed {cmd,payload} word and its one-cycle strobe;
//        tx_data/tx_valid read data from RAM; busy state != IDLE; frame_err abort/bad-cmd/timeout pulse
module spi_slave_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err
);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE} state_t;
  localparam int CW = ($clog2(DATA_W + 1) > 8) ? $clog2(DATA_W + 1) : 8;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [DATA_W:0]   rx_sr, rx_sr_nx;
  logic [DATA_W-1:0] tx_sr, tx_sr_nx;
  logic [DATA_W+1:0] rx_data_nx, word;
  logic              miso_nx, rx_valid_nx, frame_err_nx, seen, seen_nx, ok;
  assign busy = state != IDLE;
  // full frame as it stands on the edge that samples the last bit
  assign word = {rx_sr, mosi};
  // READ_ADD needs bit DATA_W clear, READ_DATA needs it set, WRITE takes either
  assign ok = (state == WRITE) || ((state == READ_DATA) == word[DATA_W]);
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rx_sr_nx     = rx_sr;
    tx_sr_nx     = tx_sr;
    miso_nx      = 1'b0;
    rx_data_nx   = rx_data;
    rx_valid_nx  = 1'b0;
    frame_err_nx = 1'b0;
    seen_nx      = seen;
    case (state)
      IDLE: begin
        cnt_nx   = '0;
        state_nx = ss_n ? IDLE : CHK_CMD;
      end
      CHK_CMD: begin
        rx_sr_nx = {rx_sr[DATA_W-1:0], mosi};
        cnt_nx   = '0;
        state_nx = ss_n ? IDLE : !mosi ? WRITE : seen ? READ_DATA : READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (ss_n) begin
          state_nx     = IDLE;
          frame_err_nx = 1'b1;
        end else if (cnt == CW'(DATA_W)) begin
          cnt_nx = '0;
          if (ok) begin
            rx_data_nx  = word;
            rx_valid_nx = 1'b1;
            seen_nx     = (state == READ_ADD) ? 1'b1 : (state == READ_DATA) ? 1'b0 : seen;
            state_nx    = (state == READ_DATA) ? WAIT_TX : DONE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = DONE;
          end
        end else begin
          rx_sr_nx = {rx_sr[DATA_W-1:0], mosi};
          cnt_nx   = cnt + 1'b1;
        end
      end
      WAIT_TX: begin
        if (ss_n) begin
          state_nx     = IDLE;
          frame_err_nx = 1'b1;
        end else if (tx_valid) begin
          // MSB goes out on the latching edge; tx_sr keeps the remaining bits left-aligned
          tx_sr_nx = tx_data << 1;
          miso_nx  = tx_data[DATA_W-1];
          cnt_nx   = '0;
          state_nx = SEND;
        end else if (cnt == CW'(TX_TIMEOUT - 1)) begin
          frame_err_nx = 1'b1;
          state_nx     = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SEND: begin
        if (ss_n) begin
          state_nx     = IDLE;
          frame_err_nx = 1'b1;
        end else if (cnt == CW'(DATA_W - 1)) begin
          state_nx = DONE;
        end else begin
          miso_nx  = tx_sr[DATA_W-1];
          tx_sr_nx = tx_sr << 1;
          cnt_nx   = cnt + 1'b1;
        end
      end
      DONE: state_nx = ss_n ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      seen      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rx_sr     <= rx_sr_nx;
      tx_sr     <= tx_sr_nx;
      miso      <= miso_nx;
      rx_data   <= rx_data_nx;
      rx_valid  <= rx_valid_nx;
      frame_err <= frame_err_nx;
      seen      <= seen_nx;
    end
  end
endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Parametrised SPI slave front-end that deserialises MSB-first command frames from an external master. It presents each completed frame to the attached memory as a command+payload word, and serialises read data back on `miso`. It sits between the chip pins and the single-port RAM controller. It adds the following over the previous slave:

- parametrised data width;
- command-bit checking;
- frame-abort detection;
- a tx_valid handshake with timeout;
- an explicit end-of-frame state.

## Interface
- `DATA_W`, 8: RAM address/data width. A frame carries `DATA_W+2` bits: 2 command bits followed by `DATA_W` payload bits.
- `TX_TIMEOUT`, 16: maximum number of clk edges spent waiting for `tx_valid` in a read-data frame. Range 1..255.
- `clk`  in  1  system clock; all sampling and shifting happen on its rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `ss_n`  in  1  slave select, active-low. High aborts or ends the frame.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `rx_data`  out  DATA_W+2  last completed frame: `[DATA_W+1:DATA_W]` is the command, `[DATA_W-1:0]` is the payload.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid.
- `tx_data`  in  DATA_W  read data from RAM.
- `tx_valid`  in  1  `tx_data` is valid. Sampled only in WAIT_TX.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_err`  out  1  one-cycle pulse on abort, bad command, or tx timeout.

## Operation
- Reset values: `miso`=0, `rx_valid`=0, `rx_data`=0, `frame_err`=0, `busy`=0. State is IDLE; the internal `rd_addr_seen` flag is 0.
- Command encoding:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- IDLE: `miso`=0 and the bit counter is cleared. `ss_n`=0 moves to CHK_CMD.
- CHK_CMD: sample `mosi` as command bit `DATA_W+1`, then branch:
  - `mosi`=0 → WRITE;
  - `mosi`=1 and `rd_addr_seen`=0 → READ_ADD;
  - `mosi`=1 and `rd_addr_seen`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA each shift in the remaining `DATA_W+1` bits, one per edge.
- On the last bit:
  - `rx_data` is loaded with the full word and `rx_valid` pulses for one cycle;
  - the next state is DONE, except from READ_DATA, where it is WAIT_TX.
- Command check at completion:
  - READ_ADD requires bit `DATA_W`=0; READ_DATA requires bit `DATA_W`=1. WRITE accepts either value.
  - On a mismatch: no `rx_valid`, `rx_data` is unchanged, `frame_err` pulses, next state is DONE.
- `rd_addr_seen`:
  - set on a valid READ_ADD completion;
  - cleared on a valid READ_DATA completion;
  - unaffected by WRITE frames, errors and aborts.
- WAIT_TX counts edges from 0.
  - If `tx_valid`=1: latch `tx_data` into the shift register, drive `miso` = `tx_data[DATA_W-1]` on the same edge, and go to SEND.
  - If the count reaches `TX_TIMEOUT` first: pulse `frame_err` and go to DONE with `miso`=0.
- SEND: each edge drives the next lower bit on `miso`. After bit 0 has been driven for one cycle, go to DONE. `tx_valid` is ignored in this state.
- DONE: `miso`=0. Stay until `ss_n`=1, then go to IDLE.
- Abort: `ss_n`=1 in any state except IDLE or DONE moves to IDLE on the next edge.
  - The partial frame is discarded: no `rx_valid`, `rx_data` is unchanged.
  - `frame_err` pulses, except when the abort happens in CHK_CMD.
  - `ss_n` has priority over a last bit sampled on the same edge.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately and clears `rd_addr_seen`.

## Timing
- Edge numbering: E0 is the first edge that sees `ss_n`=0 in IDLE.
- The command MSB is sampled at E1. Payload bits are sampled at E2..E(`DATA_W`+2).
- `rx_valid` is high during the cycle following E(`DATA_W`+2). For `DATA_W`=8, that is after E10.
- Read data, when `tx_valid` is already high on entry to WAIT_TX:
  - `miso` MSB appears after E(`DATA_W`+3);
  - the LSB appears after E(2·`DATA_W`+2).
- Back-to-back frames require `ss_n` to be high for at least one edge between them.
- `busy` is a combinational decode of the state register.

## Test plan
1. `DATA_W`=8, write-address frame: `ss_n` low, shift 00_1010_0101 → a single `rx_valid` pulse after E10, `rx_data`=10'h0A5, `frame_err`=0, `miso`=0 throughout.
2. Read-address frame 10_0000_0011, then read-data frame 11_xxxx_xxxx with `tx_valid`=1 and `tx_data`=8'hC3:
   - `rx_valid` is pulsed for both frames;
   - `miso` sequence is 1,1,0,0,0,0,1,1 starting the cycle after E11;
   - DONE is reached, and IDLE follows once `ss_n` rises.
3. Read-data frame with `tx_valid` held 0 and `TX_TIMEOUT`=16 → `frame_err` pulses once, 16 edges after WAIT_TX entry; `miso` stays 0.
4. Read-address frame sent with command 11 (so the second bit is 1) while `rd_addr_seen`=0 → no `rx_valid`, `frame_err` pulse, `rx_data` unchanged.
5. `ss_n` raised after E5 of a write frame → IDLE at the next edge, `frame_err` pulse, no `rx_valid`. A following full frame completes normally.
6. `rst_n` asserted in the middle of SEND → `miso`, `busy` and `rx_valid` go to 0 immediately. A subsequent 11 frame is decoded as READ_ADD, because `rd_addr_seen` was cleared, so the command check fails and `frame_err` pulses.
